// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ttt_pkg
// Brief    : Shared state encoding and line masks for the tic-tac-toe engine.
// Revision : 1.0
// ============================================================================
package ttt_pkg;

    localparam int CELLS = 9;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2,
        CLEAR = 2'd3
    } ttt_state_t;

    // Cell i is bit i, row-major from the top-left corner.
    localparam logic [8:0] WIN_LINES [8] = '{
        9'b000_000_111,
        9'b000_111_000,
        9'b111_000_000,
        9'b001_001_001,
        9'b010_010_010,
        9'b100_100_100,
        9'b100_010_001,
        9'b001_010_100
    };

endpackage
`default_nettype wire

// File: rtl/ttt_win_detect.sv
`default_nettype none
// ============================================================================
// Module   : ttt_win_detect
// Brief    : Flags a player plane that fully covers any row, column or diagonal.
// Revision : 1.0
// ============================================================================
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [CELLS-1:0] plane,
    output logic             win
);

    logic [7:0] w_hit;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_line
            assign w_hit[gi] = ((plane & WIN_LINES[gi]) == WIN_LINES[gi]);
        end
    endgenerate

    assign win = |w_hit;

endmodule
`default_nettype wire

// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ttt_game_ctrl
// Brief    : Tic-tac-toe move engine: debounced key, legality, win/draw, scores.
// Revision : 1.0
// ============================================================================
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int LOCKOUT     = 5_000_000,
    parameter int SCORE_MAX   = 10
) (
    input  logic        clk,
    input  logic        resetG,
    input  logic        KEY,
    input  logic [3:0]  sel,
    input  logic        new_game,
    output logic [17:0] p,
    output logic        turn,
    output logic [3:0]  win1,
    output logic [3:0]  win2,
    output logic        game_over,
    output logic        illegal
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int LOCK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT + 1) : 1;

    logic              r_key_meta_q, r_key_sync_q, r_key_prev_q;
    logic [LOCK_W-1:0] r_lock_q, w_lock_d;
    logic [HOLD_W-1:0] r_hold_q, w_hold_d;
    ttt_state_t        r_state_q, w_state_d;
    logic [17:0]       r_p_q, w_p_d;
    logic              r_turn_q, w_turn_d;
    logic [3:0]        r_win1_q, w_win1_d;
    logic [3:0]        r_win2_q, w_win2_d;
    logic              r_game_over_q, w_game_over_d;
    logic              r_illegal_q, w_illegal_d;

    logic             w_press;
    logic [CELLS-1:0] w_occ, w_onehot, w_mover_plane;
    logic             w_legal, w_win, w_full;

    // Key is active-low and asynchronous; sync chain idles high.
    always_ff @(posedge clk or negedge resetG) begin
        if (!resetG) begin
            r_key_meta_q <= 1'b1;
            r_key_sync_q <= 1'b1;
            r_key_prev_q <= 1'b1;
        end else begin
            r_key_meta_q <= KEY;
            r_key_sync_q <= r_key_meta_q;
            r_key_prev_q <= r_key_sync_q;
        end
    end

    assign w_press = r_key_prev_q & ~r_key_sync_q & (r_lock_q == '0);

    always_comb begin
        w_lock_d = r_lock_q;
        if (w_press) begin
            w_lock_d = LOCK_W'(LOCKOUT);
        end else if (r_lock_q != '0) begin
            w_lock_d = r_lock_q - 1'b1;
        end
    end

    assign w_occ         = r_p_q[8:0] | r_p_q[17:9];
    assign w_onehot      = 9'd1 << sel;
    assign w_legal       = (sel <= 4'd8) && ((w_occ & w_onehot) == '0);
    assign w_mover_plane = r_turn_q ? r_p_q[17:9] : r_p_q[8:0];
    assign w_full        = &w_occ;

    ttt_win_detect u_win_detect (
        .plane (w_mover_plane),
        .win   (w_win)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_p_d         = r_p_q;
        w_turn_d      = r_turn_q;
        w_win1_d      = r_win1_q;
        w_win2_d      = r_win2_q;
        w_game_over_d = r_game_over_q;
        w_hold_d      = r_hold_q;
        w_illegal_d   = 1'b0;

        if (new_game) begin
            w_state_d     = PLAY;
            w_p_d         = '0;
            w_turn_d      = 1'b0;
            w_game_over_d = 1'b0;
            w_hold_d      = '0;
        end else begin
            case (r_state_q)
                PLAY: begin
                    if (w_press) begin
                        if (w_legal) begin
                            if (r_turn_q) w_p_d[17:9] = r_p_q[17:9] | w_onehot;
                            else          w_p_d[8:0]  = r_p_q[8:0]  | w_onehot;
                            w_state_d = CHECK;
                        end else begin
                            w_illegal_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (w_win || w_full) begin
                        w_state_d     = HOLD;
                        w_game_over_d = 1'b1;
                        w_hold_d      = '0;
                        if (w_win && r_turn_q && (r_win2_q != 4'(SCORE_MAX))) begin
                            w_win2_d = r_win2_q + 4'd1;
                        end
                        if (w_win && !r_turn_q && (r_win1_q != 4'(SCORE_MAX))) begin
                            w_win1_d = r_win1_q + 4'd1;
                        end
                    end else begin
                        w_turn_d  = ~r_turn_q;
                        w_state_d = PLAY;
                    end
                end
                HOLD: begin
                    // Board is wiped on entry to CLEAR so game_over spans exactly HOLD_CYCLES.
                    if (r_hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                        w_state_d     = CLEAR;
                        w_p_d         = '0;
                        w_turn_d      = 1'b0;
                        w_game_over_d = 1'b0;
                        w_hold_d      = '0;
                    end else begin
                        w_hold_d = r_hold_q + 1'b1;
                    end
                end
                CLEAR: begin
                    w_state_d     = PLAY;
                    w_p_d         = '0;
                    w_turn_d      = 1'b0;
                    w_game_over_d = 1'b0;
                end
                default: w_state_d = PLAY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetG) begin
        if (!resetG) begin
            r_state_q     <= PLAY;
            r_p_q         <= '0;
            r_turn_q      <= 1'b0;
            r_win1_q      <= '0;
            r_win2_q      <= '0;
            r_game_over_q <= 1'b0;
            r_illegal_q   <= 1'b0;
            r_hold_q      <= '0;
            r_lock_q      <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_p_q         <= w_p_d;
            r_turn_q      <= w_turn_d;
            r_win1_q      <= w_win1_d;
            r_win2_q      <= w_win2_d;
            r_game_over_q <= w_game_over_d;
            r_illegal_q   <= w_illegal_d;
            r_hold_q      <= w_hold_d;
            r_lock_q      <= w_lock_d;
        end
    end

    assign p         = r_p_q;
    assign turn      = r_turn_q;
    assign win1      = r_win1_q;
    assign win2      = r_win2_q;
    assign game_over = r_game_over_q;
    assign illegal   = r_illegal_q;

endmodule
`default_nettype wire
